// File: rtl/seg7_scan_receiver_if.sv
// Scanned 7-segment display bus: the display driver (master) presents scan select and segments,
// the receiver (slave) returns the decoded digits, pulses and error state; SEG7_RX_ERRCNT_EN adds err_count.
interface seg7_scan_receiver_if;
    logic [1:0] scan_select;
    logic [7:0] seg7;
    logic       err_clr;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       valid0;
    logic       valid1;
    logic       dp0;
    logic       dp1;
    logic       upd;
    logic       pat_err;
    logic       err;
`ifdef SEG7_RX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    modport master (
        output scan_select, seg7, err_clr,
`ifdef SEG7_RX_ERRCNT_EN
        input  err_count,
`endif
        input  digit0, digit1, valid0, valid1, dp0, dp1, upd, pat_err, err
    );

    modport slave (
        input  scan_select, seg7, err_clr,
`ifdef SEG7_RX_ERRCNT_EN
        output err_count,
`endif
        output digit0, digit1, valid0, valid1, dp0, dp1, upd, pat_err, err
    );
endinterface

// File: rtl/seg7_scan_receiver.sv
// Deglitches and decodes a scanned 7-seg bus; outputs update STABLE_CYCLES edges after the input settles.
// No backpressure, inputs are sampled every cycle; defining SEG7_RX_ERRCNT_EN adds the saturating err_count port.
module seg7_scan_receiver #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    seg7_scan_receiver_if.slave  bus
);

    localparam logic [7:0] STABLE = STABLE_CYCLES[7:0];

    logic [9:0] smp_in;
    logic [9:0] smp;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       fire;
    logic       fire_nxt;
    logic       diff;

    logic [3:0] digit0_q;
    logic [3:0] digit1_q;
    logic       valid0_q;
    logic       valid1_q;
    logic       dp0_q;
    logic       dp1_q;
    logic       upd_q;
    logic       pat_err_q;
    logic       err_q;

    logic       sel_d0;
    logic       sel_d1;
    logic       blank;
    logic       legal;
    logic [3:0] value;
    logic       acc;
    logic       set_err;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] d;
        case (p)
            7'h7E:   d = {1'b1, 4'h0};
            7'h30:   d = {1'b1, 4'h1};
            7'h6D:   d = {1'b1, 4'h2};
            7'h79:   d = {1'b1, 4'h3};
            7'h33:   d = {1'b1, 4'h4};
            7'h5B:   d = {1'b1, 4'h5};
            7'h5F:   d = {1'b1, 4'h6};
            7'h70:   d = {1'b1, 4'h7};
            7'h7F:   d = {1'b1, 4'h8};
            7'h7B:   d = {1'b1, 4'h9};
            7'h77:   d = {1'b1, 4'hA};
            7'h1F:   d = {1'b1, 4'hB};
            7'h4E:   d = {1'b1, 4'hC};
            7'h3D:   d = {1'b1, 4'hD};
            7'h4F:   d = {1'b1, 4'hE};
            7'h47:   d = {1'b1, 4'hF};
            default: d = 5'd0;
        endcase
        return d;
    endfunction

    assign smp_in = {bus.scan_select, bus.seg7};

    // fire is raised only on the edge the count first lands on STABLE, so a held input never re-accepts
    always_comb begin
        diff     = (smp_in != smp);
        cnt_nxt  = cnt;
        if (diff)
            cnt_nxt = 8'd1;
        else if (cnt >= STABLE)
            cnt_nxt = STABLE;
        else
            cnt_nxt = cnt + 8'd1;
        fire_nxt = (cnt_nxt == STABLE) && (diff || (cnt != STABLE));
    end

    always_comb begin
        sel_d0         = (smp[9:8] == 2'b01);
        sel_d1         = (smp[9:8] == 2'b10);
        blank          = (smp[6:0] == 7'd0);
        {legal, value} = decode(smp[6:0]);
        acc            = fire && (sel_d0 || sel_d1);
        set_err        = acc && !legal && !blank;
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            smp       <= '0;
            cnt       <= '0;
            fire      <= 1'b0;
            digit0_q  <= '0;
            digit1_q  <= '0;
            valid0_q  <= 1'b0;
            valid1_q  <= 1'b0;
            dp0_q     <= 1'b0;
            dp1_q     <= 1'b0;
            upd_q     <= 1'b0;
            pat_err_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            smp       <= smp_in;
            cnt       <= cnt_nxt;
            fire      <= fire_nxt;
            upd_q     <= 1'b0;
            pat_err_q <= 1'b0;
            if (acc) begin
                if (legal) begin
                    if (sel_d0) begin
                        digit0_q <= value;
                        valid0_q <= 1'b1;
                        dp0_q    <= smp[7];
                    end else begin
                        digit1_q <= value;
                        valid1_q <= 1'b1;
                        dp1_q    <= smp[7];
                    end
                    upd_q <= 1'b1;
                end else begin
                    // blank and illegal both invalidate the digit but keep its last value and DP
                    if (sel_d0)
                        valid0_q <= 1'b0;
                    else
                        valid1_q <= 1'b0;
                    upd_q     <= blank;
                    pat_err_q <= !blank;
                end
            end
            if (set_err)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

`ifdef SEG7_RX_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clock) begin
        if (!rst)
            err_cnt <= '0;
        else if (bus.err_clr)
            err_cnt <= set_err ? 8'd1 : 8'd0;
        else if (set_err && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end

    assign bus.err_count = err_cnt;
`endif

    assign bus.digit0  = digit0_q;
    assign bus.digit1  = digit1_q;
    assign bus.valid0  = valid0_q;
    assign bus.valid1  = valid1_q;
    assign bus.dp0     = dp0_q;
    assign bus.dp1     = dp1_q;
    assign bus.upd     = upd_q;
    assign bus.pat_err = pat_err_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_seg7_scan_receiver.sv
// Bench for seg7_scan_receiver: vector table with per-vector end state plus a queue of expected
// upd/pat_err events, each stamped with the cycle it must appear in; a second instance runs STABLE_CYCLES=1.
module tb_seg7_scan_receiver;

    localparam int S = 4;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  seg;
        int          hold;
        int          ev;     // 0 none, 1 upd, 2 pat_err
        logic [10:0] st;     // {digit0, valid0, dp0, digit1, valid1, dp1, err}
    } vec_t;

    typedef struct {
        int          stamp;
        int          ev;
        logic [10:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_receiver_if bus ();
    seg7_scan_receiver_if bus1 ();

    assign bus1.scan_select = bus.scan_select;
    assign bus1.seg7        = bus.seg7;
    assign bus1.err_clr     = bus.err_clr;

    seg7_scan_receiver #(.STABLE_CYCLES(S)) dut  (.clock(clk), .rst(rst), .bus(bus));
    seg7_scan_receiver #(.STABLE_CYCLES(1)) dut1 (.clock(clk), .rst(rst), .bus(bus1));

    function automatic logic [10:0] st_of(int d0, int v0, int p0, int d1, int v1, int p1, int e);
        return {d0[3:0], v0[0], p0[0], d1[3:0], v1[0], p1[0], e[0]};
    endfunction

    function automatic vec_t mk(int sel, int seg, int hold, int ev, logic [10:0] st);
        vec_t v;
        v.sel  = sel[1:0];
        v.seg  = seg[7:0];
        v.hold = hold;
        v.ev   = ev;
        v.st   = st;
        return v;
    endfunction

    function automatic logic [10:0] cur_st();
        return {bus.digit0, bus.valid0, bus.dp0, bus.digit1, bus.valid1, bus.dp1, bus.err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string name, input vec_t v);
        bus.scan_select = v.sel;
        bus.seg7        = v.seg;
        if (v.ev != 0)
            sb.push_back(exp_t'{cyc + 1 + S, v.ev, v.st});
        repeat (v.hold) tick();
        chk({name, " state"}, 32'(cur_st()), 32'(v.st));
    endtask

    initial begin
        bus.scan_select = 2'b00;
        bus.seg7        = 8'h00;
        bus.err_clr     = 1'b0;

        tbl.push_back(mk(2'b10, 8'h7E, 6, 1, st_of(0, 0, 0, 'h0, 1, 0, 0)));
        tbl.push_back(mk(2'b01, 8'hC7, 6, 1, st_of('hF, 1, 1, 'h0, 1, 0, 0)));
        tbl.push_back(mk(2'b01, 8'h00, 6, 1, st_of('hF, 0, 1, 'h0, 1, 0, 0)));
        tbl.push_back(mk(2'b10, 8'h30, 2, 0, st_of('hF, 0, 1, 'h0, 1, 0, 0)));
        tbl.push_back(mk(2'b10, 8'h6D, 2, 0, st_of('hF, 0, 1, 'h0, 1, 0, 0)));
        tbl.push_back(mk(2'b10, 8'h30, 2, 0, st_of('hF, 0, 1, 'h0, 1, 0, 0)));
        tbl.push_back(mk(2'b10, 8'h6D, 2, 0, st_of('hF, 0, 1, 'h0, 1, 0, 0)));
        tbl.push_back(mk(2'b01, 8'h01, 6, 2, st_of('hF, 0, 1, 'h0, 1, 0, 1)));
        tbl.push_back(mk(2'b11, 8'h79, 6, 0, st_of('hF, 0, 1, 'h0, 1, 0, 1)));
        tbl.push_back(mk(2'b10, 8'h79, 6, 1, st_of('hF, 0, 1, 'h3, 1, 0, 1)));
        tbl.push_back(mk(2'b10, 8'hF7, 6, 1, st_of('hF, 0, 1, 'hA, 1, 1, 1)));
        tbl.push_back(mk(2'b01, 8'h5B, 6, 1, st_of('h5, 1, 0, 'hA, 1, 1, 1)));
        tbl.push_back(mk(2'b01, 8'h4F, 3, 0, st_of('h5, 1, 0, 'hA, 1, 1, 1)));
        tbl.push_back(mk(2'b10, 8'h00, 6, 1, st_of('h5, 1, 0, 'hA, 0, 1, 1)));
        tbl.push_back(mk(2'b00, 8'h30, 6, 0, st_of('h5, 1, 0, 'hA, 0, 1, 1)));

        fork
            forever begin
                @(negedge clk);
                if (rst && (bus.upd || bus.pat_err)) begin
                    exp_t e;
                    if (sb.size() == 0) begin
                        chk("unexpected pulse", 32'({bus.pat_err, bus.upd}), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("event cycle", 32'(cyc), 32'(e.stamp));
                        chk("event kind", 32'({bus.pat_err, bus.upd}), 32'(e.ev));
                        chk("event state", 32'(cur_st()), 32'(e.st));
                    end
                end
            end
        join_none

        tick();
        tick();
        chk("reset state", 32'(cur_st()), 32'(0));
        chk("reset pulses", 32'({bus.upd, bus.pat_err}), 32'(0));
`ifdef SEG7_RX_ERRCNT_EN
        chk("reset err_count", 32'(bus.err_count), 32'(0));
`endif
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i]);
`ifdef SEG7_RX_ERRCNT_EN
        chk("err_count after first illegal", 32'(bus.err_count), 32'(1));
`endif

        // err_clr lands on the same edge as an illegal accept: the set must win
        bus.scan_select = 2'b01;
        bus.seg7        = 8'h01;
        sb.push_back(exp_t'{cyc + 1 + S, 2, st_of('h5, 0, 0, 'hA, 0, 1, 1)});
        repeat (S) tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("err with clr+illegal", 32'(bus.err), 32'(1));
`ifdef SEG7_RX_ERRCNT_EN
        chk("err_count with clr+illegal", 32'(bus.err_count), 32'(1));
`endif
        tick();

        apply("illegal on digit1", mk(2'b10, 8'h02, 6, 2, st_of('h5, 0, 0, 'hA, 0, 1, 1)));
`ifdef SEG7_RX_ERRCNT_EN
        chk("err_count second illegal", 32'(bus.err_count), 32'(2));
`endif

        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("err_clr alone", 32'(cur_st()), 32'(st_of('h5, 0, 0, 'hA, 0, 1, 0)));
`ifdef SEG7_RX_ERRCNT_EN
        chk("err_count cleared", 32'(bus.err_count), 32'(0));
`endif

        // reset on the third edge of a stable run, then a full fresh run is required
        bus.scan_select = 2'b01;
        bus.seg7        = 8'h33;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mid-run reset state", 32'(cur_st()), 32'(0));
        chk("mid-run reset pulses", 32'({bus.upd, bus.pat_err}), 32'(0));
        rst = 1'b1;
        sb.push_back(exp_t'{cyc + 1 + S, 1, st_of('h4, 1, 0, 0, 0, 0, 0)});
        repeat (S) tick();
        chk("no early accept after reset", 32'({bus.digit0, bus.valid0}), 32'(0));
        tick();
        chk("digit0 after fresh run", 32'({bus.digit0, bus.valid0}), 32'({4'h4, 1'b1}));

        // STABLE_CYCLES=1 instance accepts every change one edge after sampling it
        bus.scan_select = 2'b10;
        bus.seg7        = 8'h30;
        tick();
        bus.seg7 = 8'h6D;
        tick();
        chk("s1 accept 30", 32'({bus1.digit1, bus1.valid1, bus1.upd}), 32'({4'h1, 1'b1, 1'b1}));
        bus.seg7 = 8'h30;
        tick();
        chk("s1 accept 6D", 32'({bus1.digit1, bus1.valid1, bus1.upd}), 32'({4'h2, 1'b1, 1'b1}));
        tick();
        chk("s1 accept 30 again", 32'({bus1.digit1, bus1.valid1, bus1.upd}), 32'({4'h1, 1'b1, 1'b1}));
        tick();
        chk("s1 held no re-accept", 32'({bus1.digit1, bus1.upd}), 32'({4'h1, 1'b0}));

        bus.scan_select = 2'b00;
        bus.seg7        = 8'h00;
        repeat (8) tick();
        chk("scoreboard drained", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
